// File: rtl/result_collector_pkg.sv
// Shared definitions for the matrix-multiplier result path.
// Holds the collector state encoding, the default widths, and the 2n-bit
// element-count type that the multiplier controller also uses.
package result_collector_pkg;

  localparam int unsigned N_DEF = 8;   // operand/dimension width
  localparam int unsigned M_DEF = 10;  // C-buffer address width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } rc_state_e;

  // Element count d0*d2 at the default operand width
  typedef logic [2*N_DEF-1:0] total_t;

  // Full-width product of two default-width dimensions
  function automatic total_t calc_total(input logic [N_DEF-1:0] a,
                                        input logic [N_DEF-1:0] b);
    return total_t'(a) * total_t'(b);
  endfunction

endpackage : result_collector_pkg

// File: rtl/result_collector_c_buffer.sv
// C buffer: simple dual-port RAM, 2^AW x DW.
// Synchronous write; registered synchronous read with read enable so the
// read register holds its word while the consumer stalls. No array reset.
// Ports:
//   clk      clock
//   we_i     write enable, waddr_i/wdata_i write address/data
//   re_i     read enable, raddr_i read address
//   rdata_o  read data, valid one cycle after re_i
module result_collector_c_buffer
  import result_collector_pkg::*;
#(
  parameter int unsigned AW = M_DEF,
  parameter int unsigned DW = 2 * N_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule : result_collector_c_buffer

// File: rtl/result_collector.sv
// Result collector: captures the multiplier's row-major C stream into a
// buffer, then drains it over a ready/valid port tagged with row/column.
// Flags short/long streams (len_err) and oversize matrices (size_err).
// Ports:
//   clk, rst (async, active-low)
//   start, d0, d2            matrix start and dimensions
//   valid, result, done      multiplier result stream
//   rd_ready / rd_valid, rd_data, rd_row, rd_col, rd_last   read port
//   busy, finished, len_err, size_err                       status
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned n = N_DEF,
  parameter int unsigned m = M_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   d0,
  input  logic [n-1:0]   d2,
  input  logic           valid,
  input  logic [2*n-1:0] result,
  input  logic           done,
  input  logic           rd_ready,
  output logic           rd_valid,
  output logic [2*n-1:0] rd_data,
  output logic [n-1:0]   rd_row,
  output logic [n-1:0]   rd_col,
  output logic           rd_last,
  output logic           busy,
  output logic           finished,
  output logic           len_err,
  output logic           size_err
);

  localparam int unsigned TW    = 2 * n;
  localparam int unsigned DEPTH = 1 << m;

  rc_state_e       state_q, state_d;
  logic [n-1:0]    d2_q, d2_d;
  logic [TW-1:0]   total_q, total_d;
  logic [TW-1:0]   len_q, len_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]   raddr_q, raddr_d;
  logic [n-1:0]    rrow_q, rrow_d;
  logic [n-1:0]    rcol_q, rcol_d;
  logic            s1_vld_q, s1_vld_d;
  logic [n-1:0]    s1_row_q, s1_row_d;
  logic [n-1:0]    s1_col_q, s1_col_d;
  logic            s1_last_q, s1_last_d;
  logic            rd_valid_q, rd_valid_d;
  logic [TW-1:0]   rd_data_q, rd_data_d;
  logic [n-1:0]    rd_row_q, rd_row_d;
  logic [n-1:0]    rd_col_q, rd_col_d;
  logic            rd_last_q, rd_last_d;
  logic            busy_q, busy_d;
  logic            finished_q, finished_d;
  logic            len_err_q, len_err_d;
  logic            size_err_q, size_err_d;

  logic [TW-1:0]   prod_c;
  logic [TW-1:0]   wcnt_inc_c;
  logic            advance_c;
  logic            issue_c;
  logic            we_c;
  logic            re_c;
  logic [TW-1:0]   ram_rdata;

  result_collector_c_buffer #(
    .AW (m),
    .DW (TW)
  ) u_c_buffer (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (wcnt_q[m-1:0]),
    .wdata_i (result),
    .re_i    (re_c),
    .raddr_i (raddr_q[m-1:0]),
    .rdata_o (ram_rdata)
  );

  // Next-state, counters, read pipeline and status
  always_comb begin
    state_d    = state_q;
    d2_d       = d2_q;
    total_d    = total_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    raddr_d    = raddr_q;
    rrow_d     = rrow_q;
    rcol_d     = rcol_q;
    s1_vld_d   = s1_vld_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;
    s1_last_d  = s1_last_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    rd_last_d  = rd_last_q;
    finished_d = 1'b0;
    len_err_d  = len_err_q;
    size_err_d = size_err_q;
    we_c       = 1'b0;
    re_c       = 1'b0;
    issue_c    = 1'b0;
    prod_c     = TW'(d0) * TW'(d2);
    // Count as seen after this cycle's word is written
    wcnt_inc_c = wcnt_q + TW'(valid);
    // Whole read pipeline moves together when the output slot frees up
    advance_c  = !rd_valid_q || rd_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          d2_d       = d2;
          total_d    = prod_c;
          len_d      = prod_c;
          wcnt_d     = '0;
          raddr_d    = '0;
          rrow_d     = '0;
          rcol_d     = '0;
          len_err_d  = 1'b0;
          size_err_d = 1'b0;
          if (prod_c == '0) begin
            finished_d = 1'b1;
          end else if (prod_c > TW'(DEPTH)) begin
            size_err_d = 1'b1;
            finished_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (valid) begin
          we_c   = 1'b1;
          wcnt_d = wcnt_inc_c;
        end
        if (wcnt_inc_c == total_q) begin
          state_d = ST_DRAIN;
          len_d   = total_q;
          if (!done) len_err_d = 1'b1;
        end else if (done) begin
          // Short stream: drain only what arrived
          len_err_d = 1'b1;
          len_d     = wcnt_inc_c;
          if (wcnt_inc_c == '0) begin
            finished_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (advance_c) begin
          // Output slot takes the word already sitting in the RAM read register
          rd_valid_d = s1_vld_q;
          if (s1_vld_q) begin
            rd_data_d = ram_rdata;
            rd_row_d  = s1_row_q;
            rd_col_d  = s1_col_q;
            rd_last_d = s1_last_q;
          end
          issue_c  = (raddr_q < len_q);
          s1_vld_d = issue_c;
          if (issue_c) begin
            re_c      = 1'b1;
            s1_row_d  = rrow_q;
            s1_col_d  = rcol_q;
            s1_last_d = (raddr_q == len_q - TW'(1));
            raddr_d   = raddr_q + TW'(1);
            if (rcol_q == d2_q - n'(1)) begin
              rcol_d = '0;
              rrow_d = rrow_q + n'(1);
            end else begin
              rcol_d = rcol_q + n'(1);
            end
          end
        end
        if (rd_valid_q && rd_ready && rd_last_q) begin
          state_d    = ST_IDLE;
          finished_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Words arriving outside COLLECT are dropped
    if (valid && (state_q != ST_COLLECT)) len_err_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      d2_q       <= '0;
      total_q    <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      raddr_q    <= '0;
      rrow_q     <= '0;
      rcol_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_last_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      len_err_q  <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      d2_q       <= d2_d;
      total_q    <= total_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      raddr_q    <= raddr_d;
      rrow_q     <= rrow_d;
      rcol_q     <= rcol_d;
      s1_vld_q   <= s1_vld_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      s1_last_q  <= s1_last_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      len_err_q  <= len_err_d;
      size_err_q <= size_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_row   = rd_row_q;
  assign rd_col   = rd_col_q;
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;
  assign finished = finished_q;
  assign len_err  = len_err_q;
  assign size_err = size_err_q;

endmodule : result_collector

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: normal drain, stalled drain, short
// stream, empty and oversize matrices, reset mid-drain, stray valid.
module tb_result_collector;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  d0;
  logic [7:0]  d2;
  logic        valid;
  logic [15:0] result;
  logic        done;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [7:0]  rd_row;
  logic [7:0]  rd_col;
  logic        rd_last;
  logic        busy;
  logic        finished;
  logic        len_err;
  logic        size_err;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_data [6] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
  logic [7:0]  exp_row  [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
  logic [7:0]  exp_col  [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
  bit          pat      [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  result_collector dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .d0       (d0),
    .d2       (d2),
    .valid    (valid),
    .result   (result),
    .done     (done),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_last  (rd_last),
    .busy     (busy),
    .finished (finished),
    .len_err  (len_err),
    .size_err (size_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; d0 = a; d2 = b;
    step();
    start = 1'b0;
  endtask

  // Send `count` words from exp_data; done rides with word done_at (-1: none)
  task automatic send_stream(input int count, input int done_at);
    for (int i = 0; i < count; i++) begin
      valid  = 1'b1;
      result = exp_data[i];
      done   = (i == done_at);
      step();
    end
    valid = 1'b0;
    done  = 1'b0;
  endtask

  // Accept n_exp beats; optionally toggle rd_ready 1,0,0,1 and check holds
  task automatic drain(input string tag, input int n_exp, input bit toggle);
    int got = 0;
    int cyc = 0;
    int p = 0;
    bit stalled = 1'b0;
    logic [15:0] hd = '0;
    logic [7:0]  hr = '0;
    logic [7:0]  hc = '0;
    while (got < n_exp && cyc < 80) begin
      rd_ready = toggle ? pat[p % 4] : 1'b1;
      p++;
      if (stalled) begin
        chk({tag, "_hold_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_hold_data"}, 32'(rd_data), 32'(hd));
        chk({tag, "_hold_row"}, 32'(rd_row), 32'(hr));
        chk({tag, "_hold_col"}, 32'(rd_col), 32'(hc));
      end
      stalled = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          chk({tag, "_data"}, 32'(rd_data), 32'(exp_data[got]));
          chk({tag, "_row"}, 32'(rd_row), 32'(exp_row[got]));
          chk({tag, "_col"}, 32'(rd_col), 32'(exp_col[got]));
          chk({tag, "_last"}, 32'(rd_last), 32'(got == n_exp - 1));
          got++;
        end else begin
          stalled = 1'b1;
          hd = rd_data; hr = rd_row; hc = rd_col;
        end
      end
      step();
      cyc++;
    end
    chk({tag, "_beat_count"}, 32'(got), 32'(n_exp));
    rd_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; d0 = '0; d2 = '0;
    valid = 1'b0; result = '0; done = 1'b0; rd_ready = 1'b1;
    #2 rst = 1'b0;
    step();
    step();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_size_err", 32'(size_err), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    step();

    // 2x3, full stream, done with the sixth word, ready held high
    do_start(8'd2, 8'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    send_stream(6, 5);
    chk("t1_lat0", 32'(rd_valid), 32'd0);
    step();
    chk("t1_lat1", 32'(rd_valid), 32'd0);
    step();
    chk("t1_lat2", 32'(rd_valid), 32'd1);
    drain("t1", 6, 1'b0);
    chk("t1_finished", 32'(finished), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_rd_valid_end", 32'(rd_valid), 32'd0);
    chk("t1_len_err", 32'(len_err), 32'd0);
    chk("t1_size_err", 32'(size_err), 32'd0);

    // Same stream, start coincident with finished, ready toggling
    do_start(8'd2, 8'd3);
    chk("t2_start_accepted", 32'(busy), 32'd1);
    chk("t2_finished_pulse", 32'(finished), 32'd0);
    send_stream(6, 5);
    drain("t2", 6, 1'b1);
    chk("t2_finished", 32'(finished), 32'd1);
    chk("t2_len_err", 32'(len_err), 32'd0);
    step();
    chk("t2_finished_clr", 32'(finished), 32'd0);

    // Short stream: 4 words then a lone done
    do_start(8'd2, 8'd3);
    send_stream(4, -1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t3_len_err", 32'(len_err), 32'd1);
    drain("t3", 4, 1'b0);
    chk("t3_finished", 32'(finished), 32'd1);
    step();

    // Empty matrix
    do_start(8'd0, 8'd5);
    chk("t4_finished", 32'(finished), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_rd_valid", 32'(rd_valid), 32'd0);
    step();
    chk("t4_finished_clr", 32'(finished), 32'd0);

    // Oversize matrix, 40x40 = 1600 > 1024
    do_start(8'd40, 8'd40);
    chk("t5_size_err", 32'(size_err), 32'd1);
    chk("t5_finished", 32'(finished), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    step();
    chk("t5_busy_after", 32'(busy), 32'd0);
    chk("t5_size_err_sticky", 32'(size_err), 32'd1);

    // Reset after two of six beats are drained
    do_start(8'd2, 8'd3);
    chk("t6_size_err_clr", 32'(size_err), 32'd0);
    send_stream(6, 5);
    for (int i = 0; i < 10 && !rd_valid; i++) step();
    chk("t6_first_valid", 32'(rd_valid), 32'd1);
    step();
    step();
    chk("t6_third_beat", 32'(rd_data), 32'h0033);
    rst = 1'b0;
    #1;
    chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_rd_data", 32'(rd_data), 32'd0);
    chk("t6_rst_rd_row", 32'(rd_row), 32'd0);
    chk("t6_rst_rd_col", 32'(rd_col), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_finished", 32'(finished), 32'd0);
    #1 rst = 1'b1;
    step();
    chk("t6_no_finished", 32'(finished), 32'd0);
    exp_data[0] = 16'hBEEF;
    do_start(8'd1, 8'd1);
    send_stream(1, 0);
    drain("t6", 1, 1'b0);
    chk("t6_finished", 32'(finished), 32'd1);
    chk("t6_len_err", 32'(len_err), 32'd0);
    step();

    // Stray valid in IDLE
    valid  = 1'b1;
    result = 16'h1234;
    step();
    valid = 1'b0;
    chk("t7_stray_len_err", 32'(len_err), 32'd1);
    chk("t7_stray_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_result_collector
